cnn_mac_pipe: RTL and testbench

Pipelined signed multiply-accumulate unit for CNN convolution datapaths. It generalises the single-cycle signed multiplier: operand widths and multiplier pipeline depth are parameters, and it adds a valid/last-framed accumulator, rounding right-shift, a clock enable and overflow reporting. It sits between the weight/feature-map operand fetch and the activation/output-buffer stage of a convolution layer. It emits one reduced result per framed group of products.

---
 rtl/cnn_mac_pipe.sv | 116 +++++++++++
 tb/tb_cnn_mac_pipe.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cnn_mac_pipe.sv
// rtl/cnn_mac_pipe.sv - pipelined signed MAC with framed accumulate, rounding shift and overflow flag (optional CNN_MAC_SAT_EN)
module cnn_mac_pipe #(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 6,
  parameter int ACC_WIDTH  = 32,
  parameter int DOUT_WIDTH = 16,
  parameter int SHIFT      = 0,
  parameter int NUM_STAGE  = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  // one guard bit so the rounding bias can never wrap the sum
  localparam int SW = ACC_WIDTH + 1;
  localparam logic [SW-1:0] RND = (SW'(1) << SHIFT) >> 1;
  localparam logic [DOUT_WIDTH-1:0] DMAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DOUT_WIDTH-1:0] DMIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  logic signed [PW-1:0]        r_p [NUM_STAGE];
  logic [NUM_STAGE-1:0]        r_pv;
  logic [NUM_STAGE-1:0]        r_pl;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                        r_first;
  logic                        r_acc_last;
  logic                        r_out_valid;
  logic [DOUT_WIDTH-1:0]       r_dout;
  logic                        r_ovf;

  logic signed [PW-1:0]        w_prod;
  logic signed [ACC_WIDTH-1:0] w_p_ext;
  logic signed [ACC_WIDTH-1:0] w_acc_new;
  logic signed [SW-1:0]        w_s;
  logic signed [SW-1:0]        w_r;
  logic [SW-DOUT_WIDTH:0]      w_hi;
  logic                        w_fits;
  logic [DOUT_WIDTH-1:0]       w_fit;

  assign w_prod    = $signed(din0) * $signed(din1);
  assign w_p_ext   = ACC_WIDTH'(r_p[NUM_STAGE-1]);
  assign w_acc_new = (r_first ? '0 : r_acc) + w_p_ext;

  assign w_s    = SW'(r_acc) + $signed(RND);
  assign w_r    = w_s >>> SHIFT;
  // r fits when every bit from the DOUT sign position upward agrees
  assign w_hi   = w_r[SW-1:DOUT_WIDTH-1];
  assign w_fits = (&w_hi) | ~(|w_hi);

`ifdef CNN_MAC_SAT_EN
  assign w_fit = w_fits ? w_r[DOUT_WIDTH-1:0] : (w_r[SW-1] ? DMIN : DMAX);
`else
  assign w_fit = w_r[DOUT_WIDTH-1:0];
`endif

  // multiplier pipeline: product with its valid/last tags, NUM_STAGE deep
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < NUM_STAGE; i++) r_p[i] <= '0;
      r_pv <= '0;
      r_pl <= '0;
    end else if (ce) begin
      r_p[0]  <= w_prod;
      r_pv[0] <= in_valid;
      r_pl[0] <= in_valid & in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        r_p[i]  <= r_p[i-1];
        r_pv[i] <= r_pv[i-1];
        r_pl[i] <= r_pl[i-1];
      end
    end
  end

  // accumulator: restarts from zero on the first term after a last term
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_acc      <= '0;
      r_first    <= 1'b1;
      r_acc_last <= 1'b0;
    end else if (ce) begin
      r_acc_last <= r_pv[NUM_STAGE-1] & r_pl[NUM_STAGE-1];
      if (r_pv[NUM_STAGE-1]) begin
        r_acc   <= w_acc_new;
        r_first <= r_pl[NUM_STAGE-1];
      end
    end
  end

  // output stage: round/shift the completed sum; dout and ovf hold between groups
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_ovf       <= 1'b0;
    end else if (ce) begin
      r_out_valid <= r_acc_last;
      if (r_acc_last) begin
        r_dout <= w_fit;
        r_ovf  <= ~w_fits;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// tb/tb_cnn_mac_pipe.sv - directed self-checking bench for cnn_mac_pipe
module tb_cnn_mac_pipe;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ce;
  logic        in_valid;
  logic        in_last;
  logic [13:0] din0;
  logic [5:0]  din1;
  logic        out_valid;
  logic [15:0] dout;
  logic        ovf;
  logic        s4_valid;
  logic [15:0] s4_dout;
  logic        s4_ovf;

  int total = 0;
  int bad   = 0;

`ifdef CNN_MAC_SAT_EN
  localparam logic [15:0] S1_DOUT = 16'h7FFF;
`else
  localparam logic [15:0] S1_DOUT = 16'h0000;
`endif

  always #5 ap_clk = ~ap_clk;

  cnn_mac_pipe u_dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce),
    .in_valid(in_valid), .in_last(in_last), .din0(din0), .din1(din1),
    .out_valid(out_valid), .dout(dout), .ovf(ovf)
  );

  cnn_mac_pipe #(.SHIFT(4)) u_dut_s4 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce),
    .in_valid(in_valid), .in_last(in_last), .din0(din0), .din1(din1),
    .out_valid(s4_valid), .dout(s4_dout), .ovf(s4_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic term(input logic v, input logic l, input int a, input int b);
    in_valid = v;
    in_last  = l;
    din0     = 14'(a);
    din1     = 6'(b);
  endtask

  initial begin
    ap_rst = 1'b1;
    ce     = 1'b1;
    term(0, 0, 0, 0);
    step();
    step();
    ap_rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_dout", 32'(dout), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));

    // single term overflowing 16 bits
    for (int c = 0; c <= 6; c++) begin
      if (c == 0) term(1, 1, -8192, -32);
      else        term(0, 0, 0, 0);
      chk("s1_valid", 32'(out_valid), 32'(c == 4));
      if (c == 4) begin
        chk("s1_dout", 32'(dout), 32'(S1_DOUT));
        chk("s1_ovf", 32'(ovf), 32'(1));
      end
      step();
    end

    // three-term group
    for (int c = 0; c <= 7; c++) begin
      case (c)
        0:       term(1, 0, 100, 3);
        1:       term(1, 0, -50, 2);
        2:       term(1, 1, 7, -1);
        default: term(0, 0, 0, 0);
      endcase
      chk("s2_valid", 32'(out_valid), 32'(c == 6));
      if (c == 6) begin
        chk("s2_dout", 32'(dout), 32'(193));
        chk("s2_ovf", 32'(ovf), 32'(0));
      end
      step();
    end

    // back-to-back groups
    for (int c = 0; c <= 7; c++) begin
      case (c)
        0:       term(1, 1, 10, 10);
        1:       term(1, 0, 5, 5);
        2:       term(1, 1, 1, 1);
        default: term(0, 0, 0, 0);
      endcase
      chk("s3_valid", 32'(out_valid), 32'(c == 4 || c == 6));
      if (c == 4) chk("s3_dout0", 32'(dout), 32'(100));
      if (c == 6) chk("s3_dout1", 32'(dout), 32'(26));
      step();
    end

    // stall with a term in flight, then stall with out_valid pending
    for (int c = 0; c <= 11; c++) begin
      case (c)
        0:       term(1, 0, 100, 3);
        1:       term(1, 0, -50, 2);
        2:       term(1, 1, 7, -1);
        default: term(0, 0, 0, 0);
      endcase
      ce = !(c == 3 || c == 4 || c == 5 || c == 9);
      chk("s4_valid", 32'(out_valid), 32'(c == 9 || c == 10));
      if (c >= 3 && c <= 8) chk("s4_frozen", 32'(dout), 32'(26));
      if (c == 9 || c == 10) chk("s4_dout", 32'(dout), 32'(193));
      step();
    end
    ce = 1'b1;

    // reset mid-group
    for (int c = 0; c <= 8; c++) begin
      case (c)
        0:       term(1, 0, 4, 4);
        1:       term(1, 0, 5, 5);
        3:       term(1, 1, 2, 3);
        default: term(0, 0, 0, 0);
      endcase
      ap_rst = (c == 2);
      chk("s5_valid", 32'(out_valid), 32'(c == 7));
      if (c == 3) begin
        chk("s5_rst_dout", 32'(dout), 32'(0));
        chk("s5_rst_ovf", 32'(ovf), 32'(0));
      end
      if (c == 7) chk("s5_dout", 32'(dout), 32'(6));
      step();
    end
    ap_rst = 1'b0;

    // rounding shift on the SHIFT=4 instance
    for (int c = 0; c <= 6; c++) begin
      case (c)
        0:       term(1, 1, 24, 1);
        1:       term(1, 1, -24, 1);
        default: term(0, 0, 0, 0);
      endcase
      chk("s6_valid", 32'(s4_valid), 32'(c == 4 || c == 5));
      if (c == 4) begin
        chk("s6_dout_pos", 32'(s4_dout), 32'(16'h0002));
        chk("s6_ovf_pos", 32'(s4_ovf), 32'(0));
        chk("s6_raw_pos", 32'(dout), 32'(16'h0018));
      end
      if (c == 5) begin
        chk("s6_dout_neg", 32'(s4_dout), 32'(16'hFFFF));
        chk("s6_ovf_neg", 32'(s4_ovf), 32'(0));
        chk("s6_raw_neg", 32'(dout), 32'(16'hFFE8));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
